// File: rtl/ctrl_reg8.sv
// Command sequencer for the 8-bit universal shift register: accepts one REQ/ACK command
// at a time, drives ENB/DIR/MODO/D per cycle and captures the register word at the end.
module ctrl_reg8 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [1:0]       CMD,
    input  logic             DIR_IN,
    input  logic [CNT_W-1:0] COUNT,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [WIDTH-1:0] Q_IN,
    output logic             ACK,
    output logic             BUSY,
    output logic             ENB_O,
    output logic             DIR_O,
    output logic [1:0]       MODO_O,
    output logic [WIDTH-1:0] D_O,
    output logic             SER_VALID,
    output logic             DONE,
    output logic             ERR,
    output logic [WIDTH-1:0] DATA_OUT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_SHIFT = 2'b00;
    localparam logic [1:0] CMD_ROT   = 2'b01;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    state_t           state, state_nx;
    logic [1:0]       cmd_q;
    logic             dir_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] data_out_q;

    // Shift amount is fixed by the command at acceptance time
    always_comb begin
        n_in = '0;
        case (CMD)
            CMD_SHIFT: n_in = CNT_W'(WIDTH);
            CMD_ROT:   n_in = COUNT;
            default:   n_in = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (REQ) state_nx = S_LOAD;
            S_LOAD:  state_nx = (n_q != '0) ? S_SHIFT : S_CAPT;
            S_SHIFT: if (cnt == CNT_W'(1)) state_nx = S_CAPT;
            S_CAPT:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_q      <= '0;
            dir_q      <= 1'b0;
            data_q     <= '0;
            n_q        <= '0;
            cnt        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (state == S_IDLE && REQ) begin
                cmd_q  <= CMD;
                dir_q  <= DIR_IN;
                data_q <= DATA_IN;
                n_q    <= n_in;
            end
            if (state == S_LOAD)  cnt <= n_q;
            if (state == S_SHIFT) cnt <= cnt - CNT_W'(1);
            done_q <= (state == S_CAPT);
            err_q  <= (state == S_CAPT) && (cmd_q == CMD_RSVD);
            if (state == S_CAPT) data_out_q <= Q_IN;
        end
    end

    always_comb begin
        ACK       = (state == S_LOAD);
        BUSY      = (state != S_IDLE);
        ENB_O     = 1'b0;
        MODO_O    = 2'b00;
        SER_VALID = 1'b0;
        case (state)
            S_LOAD: begin
                ENB_O  = (cmd_q != CMD_RSVD);
                MODO_O = 2'b10;
            end
            S_SHIFT: begin
                ENB_O     = 1'b1;
                MODO_O    = (cmd_q == CMD_ROT) ? 2'b01 : 2'b00;
                SER_VALID = (cmd_q == CMD_SHIFT);
            end
            default: ;
        endcase
        DIR_O    = dir_q;
        D_O      = data_q;
        DONE     = done_q;
        ERR      = err_q;
        DATA_OUT = data_out_q;
    end

endmodule

// File: tb/tb_ctrl_reg8.sv
// Directed bench for ctrl_reg8 with a behavioural shift-register model on Q_IN
// (DIR=0 shifts/rotates toward bit 0, DIR=1 toward bit 7; S_IN tied to 0).
module tb_ctrl_reg8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ;
    logic [1:0]       CMD;
    logic             DIR_IN;
    logic [CNT_W-1:0] COUNT;
    logic [WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0] Q_IN;
    logic             ACK, BUSY, ENB_O, DIR_O, SER_VALID, DONE, ERR;
    logic [1:0]       MODO_O;
    logic [WIDTH-1:0] D_O, DATA_OUT;

    logic [7:0] q_reg = 8'h00;
    logic       s_out;
    int checks = 0;
    int errors = 0;

    ctrl_reg8 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .CMD(CMD), .DIR_IN(DIR_IN), .COUNT(COUNT),
        .DATA_IN(DATA_IN), .Q_IN(Q_IN), .ACK(ACK), .BUSY(BUSY), .ENB_O(ENB_O),
        .DIR_O(DIR_O), .MODO_O(MODO_O), .D_O(D_O), .SER_VALID(SER_VALID),
        .DONE(DONE), .ERR(ERR), .DATA_OUT(DATA_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ENB_O) begin
            case (MODO_O)
                2'b10: q_reg <= D_O;
                2'b00: q_reg <= DIR_O ? {q_reg[6:0], 1'b0} : {1'b0, q_reg[7:1]};
                2'b01: q_reg <= DIR_O ? {q_reg[6:0], q_reg[7]} : {q_reg[0], q_reg[7:1]};
                default: ;
            endcase
        end
    end

    assign Q_IN  = q_reg;
    assign s_out = DIR_O ? q_reg[7] : q_reg[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue one command and track it until DONE (k=1 is the cycle after the accepting edge)
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic d,
                           input logic [3:0] n, input logic [7:0] data, input bit pulse,
                           input int exp_done, input int exp_shift, input int exp_enb,
                           input logic [7:0] exp_out);
        int ack_n = 0, ack_k = 0, done_k = 0, shift_n = 0, ser_n = 0, enb_n = 0, modo_bad = 0;
        logic [7:0] stream = '0;
        logic [1:0] exp_modo;
        exp_modo = (c == 2'b01) ? 2'b01 : 2'b00;
        CMD = c; DIR_IN = d; COUNT = n; DATA_IN = data; REQ = 1'b1;
        step();
        REQ = 1'b0; DATA_IN = ~data; COUNT = 4'(n + 4'd3); DIR_IN = ~d;
        for (int k = 1; k <= 40; k++) begin
            if (ACK) begin
                ack_n++;
                if (ack_k == 0) ack_k = k;
            end
            if (ENB_O) enb_n++;
            if (ENB_O && MODO_O != 2'b10) begin
                shift_n++;
                if (MODO_O != exp_modo) modo_bad++;
            end
            if (SER_VALID) begin
                if (ser_n < 8) stream[ser_n] = s_out;
                ser_n++;
            end
            if (DONE) begin
                done_k = k;
                break;
            end
            REQ = pulse && (k == 3 || k == 5);
            step();
        end
        REQ = 1'b0;
        chk({tag, "_ack_cycle"}, ack_k, 1);
        chk({tag, "_ack_count"}, ack_n, 1);
        chk({tag, "_done_cycle"}, done_k, exp_done);
        chk({tag, "_shift_cycles"}, shift_n, exp_shift);
        chk({tag, "_modo"}, modo_bad, 0);
        chk({tag, "_enb_cycles"}, enb_n, exp_enb);
        chk({tag, "_ser_cycles"}, ser_n, (c == 2'b00) ? 8 : 0);
        if (c == 2'b00) chk({tag, "_stream"}, stream, data);
        chk({tag, "_data_out"}, DATA_OUT, exp_out);
        chk({tag, "_err"}, ERR, (c == 2'b11) ? 1 : 0);
        step();
        chk({tag, "_done_drop"}, DONE, 0);
        chk({tag, "_err_drop"}, ERR, 0);
        chk({tag, "_idle"}, BUSY, 0);
        chk({tag, "_no_queue"}, ACK, 0);
    endtask

    initial begin
        int dones;
        RST = 1'b1; REQ = 1'b0; CMD = 2'b00; DIR_IN = 1'b0; COUNT = '0; DATA_IN = '0;
        step(); step(); step();
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_enb", ENB_O, 0);
        chk("rst_modo", MODO_O, 0);
        chk("rst_d", D_O, 0);
        chk("rst_done", DONE, 0);
        chk("rst_data_out", DATA_OUT, 0);
        RST = 1'b0;
        step();

        run_cmd("shift", 2'b00, 1'b0, 4'd0, 8'hA5, 1'b0, 11, 8, 9, 8'h00);
        run_cmd("rot3", 2'b01, 1'b1, 4'd3, 8'h81, 1'b0, 6, 3, 4, 8'h0C);
        run_cmd("load", 2'b10, 1'b0, 4'd0, 8'h3C, 1'b0, 3, 0, 1, 8'h3C);
        run_cmd("rot0", 2'b01, 1'b0, 4'd0, 8'h3C, 1'b0, 3, 0, 1, 8'h3C);
        run_cmd("rsvd", 2'b11, 1'b0, 4'd0, 8'hFF, 1'b0, 3, 0, 0, 8'h3C);
        run_cmd("rot9", 2'b01, 1'b0, 4'd9, 8'h81, 1'b0, 12, 9, 10, 8'hC0);
        run_cmd("busy_req", 2'b01, 1'b1, 4'd5, 8'h01, 1'b1, 8, 5, 6, 8'h20);

        // REQ held high through DONE is accepted in that cycle
        CMD = 2'b10; DATA_IN = 8'h5A; REQ = 1'b1;
        step();
        chk("b2b_ack1", ACK, 1);
        DATA_IN = 8'h77;
        step();
        chk("b2b_no_ack", ACK, 0);
        chk("b2b_busy", BUSY, 1);
        step();
        chk("b2b_done1", DONE, 1);
        chk("b2b_out1", DATA_OUT, 8'h5A);
        step();
        chk("b2b_ack2", ACK, 1);
        REQ = 1'b0;
        step(); step();
        chk("b2b_done2", DONE, 1);
        chk("b2b_out2", DATA_OUT, 8'h77);
        step();

        // Reset during the 4th SHIFT cycle of a shift-out
        CMD = 2'b00; DIR_IN = 1'b0; DATA_IN = 8'hC3; REQ = 1'b1;
        step();
        REQ = 1'b0;
        step(); step(); step(); step();
        chk("mid_shifting", SER_VALID, 1);
        RST = 1'b1;
        step();
        chk("mid_busy", BUSY, 0);
        chk("mid_enb", ENB_O, 0);
        chk("mid_data_out", DATA_OUT, 0);
        chk("mid_done", DONE, 0);
        chk("mid_d", D_O, 0);
        chk("mid_ser", SER_VALID, 0);
        RST = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (DONE || BUSY) dones++;
        end
        chk("mid_quiet", dones, 0);
        run_cmd("after_rst", 2'b10, 1'b0, 4'd0, 8'h96, 1'b0, 3, 0, 1, 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_reg8.md
Name: ctrl_reg8

Overview:
Sequencer for the 8-bit universal shift register (reg_desp pair). It accepts one command at a time through a REQ/ACK handshake and drives the register's ENB/DIR/MODO/D inputs cycle by cycle. Supported operations are load-and-shift-out, load-and-rotate-N, and load-only. At the end of each operation it captures the register contents and reports completion, so higher-level serial TX/RX logic never touches the register directly.

Parameters:
WIDTH, 8, register width; shift-out length equals WIDTH.
CNT_W, 4, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
CLK  input  1  rising-edge clock.
RST  input  1  synchronous, active-high reset.
REQ  input  1  command request; sampled only in IDLE.
CMD  input  2  00 shift-out, 01 rotate, 10 load-only, 11 reserved.
DIR_IN  input  1  shift/rotate direction, passed to the register.
COUNT  input  CNT_W  rotate amount (CMD=01 only).
DATA_IN  input  WIDTH  word to load.
Q_IN  input  WIDTH  register parallel output.
ACK  output  1  one-cycle pulse: command accepted.
BUSY  output  1  high whenever state != IDLE.
ENB_O  output  1  register enable.
DIR_O  output  1  register direction.
MODO_O  output  2  register mode.
D_O  output  WIDTH  register parallel-load data.
SER_VALID  output  1  high during cycles where S_OUT carries a valid shift-out bit.
DONE  output  1  one-cycle completion pulse.
ERR  output  1  qualifies DONE: reserved CMD.
DATA_OUT  output  WIDTH  captured register word; held until the next DONE.

Behaviour:
- Register mode contract:
  - ENB=0: hold.
  - MODO=10: parallel load.
  - MODO=00: shift, S_IN enters.
  - MODO=01: rotate.
- States: IDLE, LOAD, SHIFT, CAPT. Outputs are Moore, decoded from registered state/latches; there is no combinational input-to-output path.
- Reset (RST=1 at an edge, including mid-operation):
  - Next state is IDLE.
  - Latched CMD/DIR/data/count clear to 0.
  - ACK, BUSY, ENB_O, DIR_O, SER_VALID, DONE, ERR are 0; MODO_O=00; D_O=0; DATA_OUT=0.
  - The register keeps whatever it holds.
- IDLE:
  - ENB_O=0.
  - On REQ=1 at an edge: latch CMD, DIR_IN, DATA_IN, and N, then go to LOAD.
  - N is WIDTH for CMD=00, COUNT for CMD=01, 0 for CMD=10/11.
- LOAD (1 cycle):
  - ACK=1.
  - ENB_O=1 and MODO_O=10 unless CMD=11; for CMD=11, ENB_O=0.
  - D_O = latched data; DIR_O = latched DIR.
  - Next state is SHIFT if N>0, else CAPT. The counter loads N.
- SHIFT (exactly N cycles):
  - ENB_O=1; MODO_O=00 (CMD=00) or 01 (CMD=01).
  - SER_VALID=1 only for CMD=00.
  - Counter decrements every cycle; at counter=1, go to CAPT.
- CAPT (1 cycle):
  - ENB_O=0.
  - At its end: DATA_OUT<=Q_IN, DONE<=1, ERR<=(CMD==11), state<=IDLE.
  - DONE/ERR are therefore visible in the first IDLE cycle and deassert the next cycle.
- Latency, REQ at edge t:
  - ACK at t+1.
  - Shift-out: SHIFT t+2..t+9, CAPT t+10, DONE t+11.
  - Rotate N: DONE at t+N+3.
  - Load-only / reserved: DONE at t+3.
- A REQ sampled in the cycle DONE is high is accepted (back-to-back).
- A REQ while BUSY is ignored: no ACK, and it is not queued. The requester holds REQ until ACK.
- COUNT values above WIDTH are honoured literally: rotate 9 is equivalent to rotate 1. The counter never wraps because 2^CNT_W > WIDTH.
- DATA_IN/COUNT/DIR_IN changes after acceptance have no effect on the running command.

Test Plan:
- Reset, then REQ=1, CMD=00, DIR_IN=0, DATA_IN=A5, with register model S_IN=0:
  - ACK at t+1.
  - SER_VALID high exactly 8 cycles.
  - Serial stream matches the A5 bit order for DIR=0.
  - DONE at t+11, DATA_OUT=00, ERR=0.
- CMD=01, DATA_IN=81, COUNT=3, DIR_IN=1: SHIFT for 3 cycles, MODO_O=01, SER_VALID=0, DONE at t+6, DATA_OUT = 81 rotated 3 in DIR=1 direction.
- CMD=10, DATA_IN=3C: LOAD then CAPT, DONE at t+3, DATA_OUT=3C. Repeat with CMD=01, COUNT=0 and check the identical result.
- CMD=11: ACK, ENB_O never 1, DONE and ERR both high at t+3, DATA_OUT = prior register value.
- REQ pulses during BUSY produce no ACK. A new REQ held high through DONE is accepted that cycle, giving an ACK one cycle later.
- RST asserted in the 4th SHIFT cycle: next cycle BUSY=0, ENB_O=0, DATA_OUT=00, no DONE. A subsequent CMD=10 completes normally.
